arb2_rr: RTL and testbench
==========================

# arb2_rr

Two-input round-robin arbiter with a registered output stage. It sits directly upstream of the 2:1 data mux and drives that mux's select from a fair grant. It accepts two valid/ready source channels and grants one beat per cycle. The granted beat is forwarded into a one-entry output register, and the granted index is presented alongside the data.

## Interface
- `DATA_W`, default 8, width of each data channel.
- `clk` input 1: rising-edge clock, the only clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 2: per-channel valid; bit i belongs to channel i.
- `in_data` input 2*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W].
- `in_ready` output 2: per-channel ready, combinational.
- `out_valid` output 1: output register holds a beat.
- `out_data` output DATA_W: registered beat.
- `out_sel` output 1: index of the channel that supplied `out_data`. This is the 2:1 mux select.
- `out_ready` input 1: downstream accept.
- `in_last` input 2, present only with `ARB2_LOCK_EN`: marks the final beat of a packet.
- Decided: one clock, `clk`; reset `rst` is synchronous and active-high.

## Operation
- A transfer occurs on channel i when `in_valid[i] && in_ready[i]`. The output transfers when `out_valid && out_ready`.
- `can_load` = `!out_valid || out_ready`. The output register loads only when `can_load` is true.
- Grant selection:
  - Exactly one valid: grant that channel.
  - Both valid: grant channel `prio`.
  - None valid: no grant.
- `in_ready[i]` = `grant[i] && can_load`. At most one bit of `in_ready` is high. `in_ready` never depends on `in_valid` of the same channel except through the grant.
- On an input transfer from channel i:
  - `out_data` <= that channel's data, `out_sel` <= i, `out_valid` <= 1.
  - `prio` <= !i, so the other channel wins the next contention.
- On an output transfer with no input transfer: `out_valid` <= 0. `out_data` and `out_sel` hold their values.
- Simultaneous output and input transfer: the register reloads and `out_valid` stays 1, giving full throughput of one beat per cycle.
- While `out_valid && !out_ready`: `out_data` and `out_sel` are stable and both `in_ready` bits are 0.
- State machine, one-hot internally:
  - ARB: free arbitration.
  - LOCK0 and LOCK1 are used only with `ARB2_LOCK_EN`.
  - Without the macro, the FSM stays in ARB.

## Timing
- Latency: one cycle from input transfer to `out_valid`.
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `prio`=0, state=ARB, so `in_ready`=0 until a valid arrives.
- `rst` asserted mid-operation: any held beat is discarded. All state returns to reset values on the next edge. `in_ready` is forced to 0 during the reset cycle.
- `prio` updates only on an input transfer. Idle cycles and cycles where the output is stalled do not rotate it.
- Unused upper data bits do not exist: `out_data` is exactly `DATA_W` wide, and no width extension is performed.

## Configuration
- `ARB2_LOCK_EN` defined:
  - The `in_last` port exists.
  - An input transfer from channel i with `in_last[i]`=0 moves the FSM to LOCKi. While in LOCKi, only channel i is granted, regardless of `prio`.
  - A transfer with `in_last[i]`=1 returns the FSM to ARB and sets `prio` <= !i.
  - `prio` does not rotate on non-last beats.
- `ARB2_LOCK_EN` undefined:
  - The `in_last` port is absent and the FSM stays in ARB.
  - Every beat is arbitrated independently.

## Structure
- Package `arb2_pkg` holds:
  - the state enum `arb2_state_t` (ARB, LOCK0, LOCK1);
  - `ARB2_DATA_W_DEF` = 8.
- Sub-module `arb2_grant`: combinational grant logic. Its inputs are `in_valid`, `prio` and state; its output is the 2-bit grant. It is kept separate so it can be exhaustively checked.
- The output register and `prio` live in the top module.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with both channels valid → `out_valid`=0, `in_ready`=00, `out_sel`=0 throughout.
- Single channel: only channel 1 valid with data 0xA5, `out_ready`=1 → next cycle `out_valid`=1, `out_data`=0xA5, `out_sel`=1.
- Contention: both channels valid for 4 cycles, data 0x10/0x20, `out_ready`=1 → `out_sel` sequence 0,1,0,1 and `out_data` sequence 0x10,0x20,0x10,0x20.
- Backpressure: `out_ready`=0 for 5 cycles with both channels valid → `out_data` is stable, `in_ready`=00, and `prio` is unchanged. On release, the next granted channel is the one `prio` indicates.
- Reset mid-stream: assert `rst` while `out_valid`=1 → `out_valid`=0 one cycle later, and the first grant after reset goes to channel 0 under contention.
- Lock (with `ARB2_LOCK_EN`):
  - Stimulus: channel 1 sends 3 beats with `in_last`=0,0,1 while channel 0 is continuously valid.
  - Required response: `out_sel`=1,1,1, then 0.

Source files
------------

// File: rtl/arb2_pkg.sv
// arb2_pkg: shared state encoding and defaults for the two-input round-robin arbiter
package arb2_pkg;
   typedef enum logic [2:0] {
      ARB   = 3'b001,
      LOCK0 = 3'b010,
      LOCK1 = 3'b100
   } arb2_state_t;
   localparam int ARB2_DATA_W_DEF = 8;
endpackage

// File: rtl/arb2_grant.sv
// arb2_grant: combinational two-way grant from valids, round-robin priority and lock state
module arb2_grant
   import arb2_pkg::*;
(
   input  logic [1:0]  in_valid,
   input  logic        prio,
   input  arb2_state_t state,
   output logic [1:0]  grant
);
   // a lock pins the grant to its channel; otherwise prio breaks a tie
   always_comb begin
      grant = (state == LOCK0) ? {1'b0, in_valid[0]} :
              (state == LOCK1) ? {in_valid[1], 1'b0} :
              (&in_valid)      ? (prio ? 2'b10 : 2'b01) :
                                 in_valid;
   end
endmodule

// File: rtl/arb2_rr.sv
// arb2_rr: 2-input round-robin arbiter with a one-entry output register; ARB2_LOCK_EN adds packet locking via in_last
module arb2_rr
   import arb2_pkg::*;
#(
   parameter int DATA_W = ARB2_DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
`ifdef ARB2_LOCK_EN
   input  logic [1:0]        in_last,
`endif
   input  logic [1:0]        in_valid,
   input  logic [2*DATA_W-1:0] in_data,
   output logic [1:0]        in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sel,
   input  logic              out_ready
);
   arb2_state_t       r_state;
   arb2_state_t       w_state_nxt;
   logic              r_prio;
   logic              r_out_valid;
   logic              r_out_sel;
   logic [DATA_W-1:0] r_out_data;
   logic [1:0]        w_grant;
   logic [1:0]        w_xfer;
   logic              w_can_load;
   logic              w_any;
   logic              w_idx;
   logic              w_last;
   logic              w_prio_nxt;
   logic [DATA_W-1:0] w_data;

   arb2_grant u_grant (
      .in_valid (in_valid),
      .prio     (r_prio),
      .state    (r_state),
      .grant    (w_grant)
   );

   // handshake: accept only into a free or draining output register, never during reset
   always_comb begin
      w_can_load = !r_out_valid || out_ready;
      in_ready   = rst ? 2'b00 : (w_grant & {2{w_can_load}});
      w_xfer     = in_valid & in_ready;
      w_any      = |w_xfer;
      w_idx      = w_xfer[1];
      w_data     = w_idx ? in_data[DATA_W +: DATA_W] : in_data[0 +: DATA_W];
   end

   // packet boundary: without locking every beat ends its own packet
   always_comb begin
`ifdef ARB2_LOCK_EN
      w_last = in_last[w_idx];
`else
      w_last = 1'b1;
`endif
   end

   // next state and priority: rotate only when a packet completes on the granted channel
   always_comb begin
      w_state_nxt = !w_any ? r_state : (w_last ? ARB : (w_idx ? LOCK1 : LOCK0));
      w_prio_nxt  = (w_any && w_last) ? !w_idx : r_prio;
   end

   // state and priority registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ARB;
         r_prio  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_prio  <= w_prio_nxt;
      end
   end

   // output register: load on input transfer, drop valid on a bare output transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= 1'b0;
      end else if (w_any) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_data;
         r_out_sel   <= w_idx;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
endmodule

// File: tb/tb_arb2_rr.sv
// tb_arb2_rr: directed scoreboard bench for arb2_rr (lock sequence runs when ARB2_LOCK_EN is defined)
module tb_arb2_rr;
   typedef struct {
      logic       sel;
      logic [7:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  in_last;
   logic [1:0]  in_valid;
   logic [7:0]  d0, d1;
   logic [15:0] in_data;
   logic [1:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_sel;
   logic        out_ready;
   beat_t       sb[$];
   int          n_vec = 0;
   int          n_err = 0;

   assign in_data = {d1, d0};

   always #5 clk = ~clk;

   arb2_rr #(.DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef ARB2_LOCK_EN
      .in_last   (in_last),
`endif
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                       input logic rdy, input logic [1:0] lst);
      @(posedge clk);
      #1;
      rst = r; in_valid = v; d0 = a; d1 = b; out_ready = rdy; in_last = lst;
      @(negedge clk);
   endtask

   task automatic push(input logic s, input logic [7:0] d);
      beat_t e;
      e.sel = s; e.data = d;
      sb.push_back(e);
   endtask

   // monitor: every output transfer must match the oldest expected beat
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got sel=%0d data=%0h expected none", out_sel, out_data);
         end else begin
            beat_t e;
            e = sb.pop_front();
            chk("beat_sel", {31'd0, out_sel}, {31'd0, e.sel});
            chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 2'b11; d0 = 8'h10; d1 = 8'h20; out_ready = 1'b1; in_last = 2'b11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_in_ready", {30'd0, in_ready}, 32'd0);
         chk("rst_out_sel", {31'd0, out_sel}, 32'd0);
      end
      // single channel 1
      step(0, 2'b10, 8'h00, 8'hA5, 1, 2'b11);
      chk("single_in_ready", {30'd0, in_ready}, 32'd2);
      push(1, 8'hA5);
      step(0, 2'b00, 8'h00, 8'h00, 1, 2'b11);
      chk("single_in_ready_idle", {30'd0, in_ready}, 32'd0);
      step(0, 2'b00, 8'h00, 8'h00, 1, 2'b11);
      chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
      // contention: alternate starting with channel 0
      for (int i = 0; i < 4; i++) begin
         step(0, 2'b11, 8'h10, 8'h20, 1, 2'b11);
         chk("cont_in_ready", {30'd0, in_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
         push(i % 2 == 1, (i % 2 == 1) ? 8'h20 : 8'h10);
      end
      // backpressure holds the last beat (channel 1, 0x20)
      for (int i = 0; i < 5; i++) begin
         step(0, 2'b11, 8'h10, 8'h20, 0, 2'b11);
         chk("bp_in_ready", {30'd0, in_ready}, 32'd0);
         chk("bp_out_data", {24'd0, out_data}, 32'h20);
         chk("bp_out_sel", {31'd0, out_sel}, 32'd1);
      end
      // release: prio still points at channel 0
      step(0, 2'b11, 8'h10, 8'h20, 1, 2'b11);
      chk("release_in_ready", {30'd0, in_ready}, 32'd1);
      push(0, 8'h10);
      // reset while holding that beat; the beat is discarded
      step(1, 2'b11, 8'h10, 8'h20, 0, 2'b11);
      void'(sb.pop_back());
      chk("midrst_in_ready", {30'd0, in_ready}, 32'd0);
      chk("midrst_out_valid_before", {31'd0, out_valid}, 32'd1);
      step(0, 2'b11, 8'h10, 8'h20, 1, 2'b11);
      chk("midrst_out_valid_after", {31'd0, out_valid}, 32'd0);
      chk("post_rst_in_ready", {30'd0, in_ready}, 32'd1);
      push(0, 8'h10);
      // only channel 0 valid while prio favours channel 1
      step(0, 2'b01, 8'h33, 8'h44, 1, 2'b11);
      chk("single0_in_ready", {30'd0, in_ready}, 32'd1);
      push(0, 8'h33);
      step(0, 2'b11, 8'h33, 8'h44, 1, 2'b11);
      chk("cont2_in_ready", {30'd0, in_ready}, 32'd2);
      push(1, 8'h44);
`ifdef ARB2_LOCK_EN
      // give prio to channel 1, then lock on a 3-beat packet from channel 1
      step(0, 2'b01, 8'h50, 8'h60, 1, 2'b11);
      push(0, 8'h50);
      step(0, 2'b11, 8'h51, 8'h61, 1, 2'b00);
      chk("lock_b0", {30'd0, in_ready}, 32'd2);
      push(1, 8'h61);
      step(0, 2'b11, 8'h52, 8'h62, 1, 2'b00);
      chk("lock_b1", {30'd0, in_ready}, 32'd2);
      push(1, 8'h62);
      step(0, 2'b11, 8'h53, 8'h63, 1, 2'b10);
      chk("lock_b2", {30'd0, in_ready}, 32'd2);
      push(1, 8'h63);
      step(0, 2'b11, 8'h54, 8'h64, 1, 2'b11);
      chk("lock_after", {30'd0, in_ready}, 32'd1);
      push(0, 8'h54);
`endif
      step(0, 2'b00, 8'h00, 8'h00, 1, 2'b11);
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);
      step(0, 2'b00, 8'h00, 8'h00, 1, 2'b11);
      chk("final_out_valid", {31'd0, out_valid}, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
